ab_input_conditioner: RTL and testbench

- Upstream conditioning stage for the registered a&b flop stage; produces the clean `a`/`b` levels that stage samples.
- Takes two asynchronous, possibly bouncing raw inputs, synchronises each into the `clk` domain and debounces each with a stability counter.
- Outputs clean levels, one-cycle edge pulses, and a pulse when the two clean levels first become high together.

---
 rtl/ab_input_conditioner.sv | 142 ++++++++++++++
 tb/tb_ab_input_conditioner.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ab_input_conditioner.sv
// rtl/ab_input_conditioner.sv - two-channel synchroniser and debouncer with edge and both-high pulses
module ab_input_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4,
  localparam int CNT_W      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic a_raw,
  input  logic b_raw,
  output logic a_out,
  output logic b_out,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall,
  output logic both_rise
);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_CHECK  = 1'b1
  } db_state_e;

  logic [1:0] raw;
  logic [1:0] lvl_q;
  logic [1:0] lvl_d;
  logic [1:0] rise_q;
  logic [1:0] fall_q;
  logic       both_rise_q;
  logic       both_rise_d;

  assign raw = {b_raw, a_raw};

  // Channel 0 is A, channel 1 is B; they share nothing but the both_rise detector.
  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    db_state_e              state_q;
    db_state_e              state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   out_q;
    logic                   out_d;
    logic                   rise_d;
    logic                   fall_d;
    logic                   rise_r;
    logic                   fall_r;
    logic                   s_x;

    assign s_x = sync_q[SYNC_STAGES-1];

    always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], raw[ch]};
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      case (state_q)
        ST_STABLE: begin
          cnt_d = '0;
          if (s_x != out_q) begin
            if (DB_CYCLES == 1) begin
              out_d = s_x;
            end else begin
              cnt_d   = CNT_W'(1);
              state_d = ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (s_x == out_q) begin
            cnt_d   = '0;
            state_d = ST_STABLE;
          end else if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
            out_d   = s_x;
            cnt_d   = '0;
            state_d = ST_STABLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = ST_STABLE;
        end
      endcase
    end

    // Pulses are computed from the next level so they land on the same edge as the level change.
    always_comb begin
      rise_d = out_d & ~out_q;
      fall_d = ~out_d & out_q;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q  <= '0;
        state_q <= ST_STABLE;
        cnt_q   <= '0;
        out_q   <= 1'b0;
        rise_r  <= 1'b0;
        fall_r  <= 1'b0;
      end else begin
        sync_q  <= sync_d;
        state_q <= state_d;
        cnt_q   <= cnt_d;
        out_q   <= out_d;
        rise_r  <= rise_d;
        fall_r  <= fall_d;
      end
    end

    assign lvl_q[ch]  = out_q;
    assign lvl_d[ch]  = out_d;
    assign rise_q[ch] = rise_r;
    assign fall_q[ch] = fall_r;
  end

  always_comb begin
    both_rise_d = (lvl_d[0] & lvl_d[1]) & ~(lvl_q[0] & lvl_q[1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      both_rise_q <= 1'b0;
    end else begin
      both_rise_q <= both_rise_d;
    end
  end

  assign a_out     = lvl_q[0];
  assign b_out     = lvl_q[1];
  assign a_rise    = rise_q[0];
  assign a_fall    = fall_q[0];
  assign b_rise    = rise_q[1];
  assign b_fall    = fall_q[1];
  assign both_rise = both_rise_q;

endmodule

// File: tb/tb_ab_input_conditioner.sv
// tb/tb_ab_input_conditioner.sv - directed vector bench for ab_input_conditioner
module tb_ab_input_conditioner;

  typedef struct {
    logic       rst;
    logic       a;
    logic       b;
    logic [6:0] exp;
  } vec_t;

  localparam int N_MAIN = 62;
  localparam int N_FAST = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_raw = 1'b0;
  logic b_raw = 1'b0;
  logic a_out, b_out, a_rise, a_fall, b_rise, b_fall, both_rise;

  logic rst2 = 1'b1;
  logic a2_raw = 1'b0;
  logic b2_raw = 1'b0;
  logic a2_out, b2_out, a2_rise, a2_fall, b2_rise, b2_fall, both2_rise;

  int checks = 0;
  int errors = 0;

  vec_t tbl [N_MAIN];
  vec_t fast [N_FAST];

  always #5 clk = ~clk;

  ab_input_conditioner dut (
    .clk(clk), .rst(rst), .a_raw(a_raw), .b_raw(b_raw),
    .a_out(a_out), .b_out(b_out), .a_rise(a_rise), .a_fall(a_fall),
    .b_rise(b_rise), .b_fall(b_fall), .both_rise(both_rise)
  );

  ab_input_conditioner #(.SYNC_STAGES(3), .DB_CYCLES(1)) dut_fast (
    .clk(clk), .rst(rst2), .a_raw(a2_raw), .b_raw(b2_raw),
    .a_out(a2_out), .b_out(b2_out), .a_rise(a2_rise), .a_fall(a2_fall),
    .b_rise(b2_rise), .b_fall(b2_fall), .both_rise(both2_rise)
  );

  // exp bits: {a_out, b_out, a_rise, a_fall, b_rise, b_fall, both_rise}
  function automatic logic [6:0] act_main();
    return {a_out, b_out, a_rise, a_fall, b_rise, b_fall, both_rise};
  endfunction

  function automatic logic [6:0] act_fast();
    return {a2_out, b2_out, a2_rise, a2_fall, b2_rise, b2_fall, both2_rise};
  endfunction

  task automatic chk(input string name, input int idx, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %b want %b (a_out b_out a_rise a_fall b_rise b_fall both_rise)",
               name, idx, act, exp);
    end
  endtask

  task automatic set_in(input int lo, input int hi, input logic a, input logic b);
    for (int i = lo; i <= hi; i++) begin
      tbl[i].a = a;
      tbl[i].b = b;
    end
  endtask

  task automatic set_lvl(input int lo, input int hi, input int bit_idx);
    for (int i = lo; i <= hi; i++) tbl[i].exp[bit_idx] = 1'b1;
  endtask

  task automatic set_pulse(input int e, input int bit_idx);
    tbl[e].exp[bit_idx] = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N_MAIN; i++) begin
      tbl[i].rst = (i < 2);
      tbl[i].a   = 1'b0;
      tbl[i].b   = 1'b0;
      tbl[i].exp = 7'b0;
    end
    // raw inputs high during reset must not leak through
    set_in(0, 1, 1'b1, 1'b1);
    set_in(2, 3, 1'b0, 1'b0);
    set_in(4, 10, 1'b1, 1'b0);
    set_in(11, 13, 1'b0, 1'b0);
    set_in(14, 17, 1'b1, 1'b0);
    set_in(18, 24, 1'b1, 1'b1);
    set_in(25, 30, 1'b0, 1'b1);
    set_in(31, 37, 1'b1, 1'b1);
    set_in(38, 43, 1'b0, 1'b0);
    set_in(44, 50, 1'b1, 1'b1);
    set_in(51, 54, 1'b0, 1'b1);
    set_in(55, 61, 1'b1, 1'b1);

    set_lvl(9, 29, 6);
    set_lvl(36, 42, 6);
    set_lvl(49, 55, 6);
    set_lvl(60, 61, 6);
    set_lvl(23, 42, 5);
    set_lvl(49, 61, 5);
    set_pulse(9, 4);  set_pulse(36, 4); set_pulse(49, 4); set_pulse(60, 4);
    set_pulse(30, 3); set_pulse(43, 3); set_pulse(56, 3);
    set_pulse(23, 2); set_pulse(49, 2);
    set_pulse(43, 1);
    set_pulse(23, 0); set_pulse(36, 0); set_pulse(49, 0); set_pulse(60, 0);

    for (int i = 0; i < N_MAIN; i++) begin
      @(negedge clk);
      rst   = tbl[i].rst;
      a_raw = tbl[i].a;
      b_raw = tbl[i].b;
      @(posedge clk);
      #1;
      chk("main", i, act_main(), tbl[i].exp);
    end

    // Asynchronous reset in the middle of a cycle, then recovery with b held high.
    @(negedge clk);
    a_raw = 1'b0;
    b_raw = 1'b1;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst", 0, act_main(), 7'b0);
    for (int i = 1; i <= 2; i++) begin
      @(posedge clk);
      #1;
      chk("rst_hold", i, act_main(), 7'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk);
      #1;
      chk("rst_release", n, act_main(), {1'b0, (n >= 6), 2'b00, (n == 6), 2'b00});
      if (n < 8) @(negedge clk);
    end

    // SYNC_STAGES=3, DB_CYCLES=1: three-edge latency, single-cycle pulses pass straight through.
    for (int i = 0; i < N_FAST; i++) begin
      fast[i].rst = 1'b0;
      fast[i].a   = (i != 5);
      fast[i].b   = (i == 6);
      fast[i].exp = 7'b0;
    end
    for (int i = 3; i <= 10; i++) fast[i].exp[6] = (i != 8);
    fast[3].exp[4] = 1'b1;
    fast[8].exp[3] = 1'b1;
    fast[9].exp    = 7'b1110101;
    fast[10].exp   = 7'b1000010;

    for (int i = 0; i < N_FAST; i++) begin
      @(negedge clk);
      rst2   = fast[i].rst;
      a2_raw = fast[i].a;
      b2_raw = fast[i].b;
      @(posedge clk);
      #1;
      chk("fast", i, act_fast(), fast[i].exp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
